// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift link: default word size,
// direction encodings and receiver FSM states.
package shift_pkg;
  localparam int WIDTH_DEF = 8;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;
endpackage

// File: rtl/shift_rx_ctrl.sv
// Receiver sequencing: FSM, bit counter, per-word direction latch and the
// single-cycle completion pulse for the word being assembled.
module shift_rx_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sin_valid_i,
  input  logic msb_first_i,
  input  logic frame_start_i,
  output logic first_o,
  output logic dir_o,
  output logic done_o,
  output logic busy_o
);
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    first_o = 1'b0;
    done_o  = 1'b0;
    if (frame_start_i) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
    end
    if (sin_valid_i) begin
      // A bit arriving with Frame_start opens a fresh word.
      if (frame_start_i || state_q == RX_IDLE) begin
        first_o = 1'b1;
        dir_d   = msb_first_i;
        cnt_d   = CW'(1);
        state_d = RX_SHIFT;
      end else if (cnt_q == CW'(WIDTH-1)) begin
        done_o  = 1'b1;
        cnt_d   = '0;
        state_d = RX_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    dir_o = first_o ? msb_first_i : dir_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/shift_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words and presents
// them on a valid/ready holding register with sticky overrun reporting.
module shift_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Sin,
  input  logic             Sin_valid,
  input  logic             Msb_first,
  input  logic             Frame_start,
  output logic [WIDTH-1:0] Pout,
  output logic             Pout_valid,
  input  logic             Pout_ready,
  output logic             Busy,
  output logic             Overrun,
  input  logic             Clr_ovr
);
  logic             first, dir, done;
  logic [WIDTH-1:0] sr_q, sr_d, base, shifted;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pv_q, pv_d, ovr_q, ovr_d;

  shift_rx_ctrl #(.WIDTH(WIDTH), .CW(CW)) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .sin_valid_i  (Sin_valid),
    .msb_first_i  (Msb_first),
    .frame_start_i(Frame_start),
    .first_o      (first),
    .dir_o        (dir),
    .done_o       (done),
    .busy_o       (Busy)
  );

  // First bit shifts into an empty register so stale bits never leak in.
  always_comb begin
    base    = first ? '0 : sr_q;
    shifted = (dir == DIR_MSB_FIRST) ? {base[WIDTH-2:0], Sin}
                                     : {Sin, base[WIDTH-1:1]};
    sr_d = sr_q;
    if (Frame_start) sr_d = '0;
    if (Sin_valid)   sr_d = shifted;
  end

  always_comb begin
    pout_d = pout_q;
    pv_d   = pv_q;
    ovr_d  = ovr_q;
    if (Clr_ovr)           ovr_d = 1'b0;
    if (pv_q & Pout_ready) pv_d  = 1'b0;
    if (done) begin
      if (!pv_q || Pout_ready) begin
        pout_d = shifted;
        pv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      pout_q <= '0;
      pv_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      pout_q <= pout_d;
      pv_q   <= pv_d;
      ovr_q  <= ovr_d;
    end
  end

  assign Pout       = pout_q;
  assign Pout_valid = pv_q;
  assign Overrun    = ovr_q;
endmodule

// File: tb/tb_shift_rx.sv
// Directed bench for shift_rx: vector table for word assembly/handshake,
// hand sequences for Frame_start resync and asynchronous reset.
module tb_shift_rx;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       Sin, Sin_valid, Msb_first, Frame_start, Pout_ready, Clr_ovr;
  logic [7:0] Pout;
  logic       Pout_valid, Busy, Overrun;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       sin, sv, msb, fs, rdy, clr;
    logic [7:0] pout;
    logic       pv, busy, ovr;
  } vec_t;

  vec_t tbl[$];

  shift_rx #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .Sin(Sin), .Sin_valid(Sin_valid),
    .Msb_first(Msb_first), .Frame_start(Frame_start), .Pout(Pout),
    .Pout_valid(Pout_valid), .Pout_ready(Pout_ready), .Busy(Busy),
    .Overrun(Overrun), .Clr_ovr(Clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] ep,
                       input logic epv, input logic eb, input logic eo);
    n_vec++;
    if (Pout !== ep || Pout_valid !== epv || Busy !== eb || Overrun !== eo) begin
      n_bad++;
      $display("FAIL %s: got Pout=%h Pout_valid=%b Busy=%b Overrun=%b, want Pout=%h Pout_valid=%b Busy=%b Overrun=%b",
               name, Pout, Pout_valid, Busy, Overrun, ep, epv, eb, eo);
    end
  endtask

  task automatic step(input logic s, input logic sv, input logic m,
                      input logic fs, input logic r, input logic c);
    Sin = s; Sin_valid = sv; Msb_first = m; Frame_start = fs;
    Pout_ready = r; Clr_ovr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic s, input logic sv, input logic m,
                              input logic fs, input logic r, input logic c,
                              input logic [7:0] p, input logic pv,
                              input logic b, input logic o);
    vec_t v;
    v.sin = s; v.sv = sv; v.msb = m; v.fs = fs; v.rdy = r; v.clr = c;
    v.pout = p; v.pv = pv; v.busy = b; v.ovr = o;
    tbl.push_back(v);
  endfunction

  // seq[7] goes on the line first; tog>0 flips Msb_first from bit index tog on.
  function automatic void add_word(input logic [7:0] seq, input logic m,
                                   input int tog, input logic rdy_last,
                                   input logic [7:0] pre_p, input logic pre_pv,
                                   input logic pre_o, input logic [7:0] fin_p,
                                   input logic fin_pv, input logic fin_o);
    for (int i = 0; i < 8; i++) begin
      logic mm;
      mm = (tog > 0 && i >= tog) ? ~m : m;
      if (i < 7) add(seq[7-i], 1'b1, mm, 1'b0, 1'b0, 1'b0, pre_p, pre_pv, 1'b1, pre_o);
      else       add(seq[7-i], 1'b1, mm, 1'b0, rdy_last, 1'b0, fin_p, fin_pv, 1'b0, fin_o);
    end
  endfunction

  initial begin
    reset_n = 1'b0;
    Sin = 0; Sin_valid = 0; Msb_first = 0; Frame_start = 0;
    Pout_ready = 0; Clr_ovr = 0;

    // MSB-first 0,0,0,1,0,0,1,0 -> 12, then consume
    add_word(8'b0001_0010, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0);
    add(0, 0, 0, 0, 1, 0, 8'h12, 1'b0, 1'b0, 1'b0);
    // Same bits LSB-first, Msb_first toggled from bit 3 on -> 48
    add_word(8'b0001_0010, 1'b0, 3, 1'b0, 8'h12, 1'b0, 1'b0, 8'h48, 1'b1, 1'b0);
    add(0, 0, 0, 0, 1, 0, 8'h48, 1'b0, 1'b0, 1'b0);
    // A5 then 3C with no ready: 3C dropped, overrun, then clear and consume
    add_word(8'hA5, 1'b1, 0, 1'b0, 8'h48, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    add_word(8'h3C, 1'b1, 0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    add(0, 0, 0, 0, 0, 1, 8'hA5, 1'b1, 1'b0, 1'b0);
    add(0, 0, 0, 0, 1, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
    // Back-to-back, ready only on word 2 completion edge
    add_word(8'h5A, 1'b1, 0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
    add_word(8'hC3, 1'b1, 0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
    add(0, 0, 0, 0, 1, 0, 8'hC3, 1'b0, 1'b0, 1'b0);

    #2;
    check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].sin, tbl[i].sv, tbl[i].msb, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d", i), tbl[i].pout, tbl[i].pv, tbl[i].busy, tbl[i].ovr);
    end

    // Frame_start resync after 5 bits; new word 1,0,1,1,0,0,1,1 -> B3
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
    check("fs_pre", 8'hC3, 1'b0, 1'b1, 1'b0);
    step(1, 1, 1, 1, 0, 0);
    check("fs_first_bit", 8'hC3, 1'b0, 1'b1, 1'b0);
    step(0, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
    check("fs_mid", 8'hC3, 1'b0, 1'b1, 1'b0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
    check("fs_bit7", 8'hC3, 1'b0, 1'b1, 1'b0);
    step(1, 1, 1, 0, 0, 0);
    check("fs_word", 8'hB3, 1'b1, 1'b0, 1'b0);

    // Frame_start alone leaves the held word untouched
    step(0, 0, 1, 1, 0, 0);
    check("fs_keeps_pout", 8'hB3, 1'b1, 1'b0, 1'b0);
    // Sin_valid gap holds the partial word
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    check("gap_hold", 8'hB3, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges, 4 bits in
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    check("pre_async_rst", 8'hB3, 1'b1, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0, 0);
    check("ff_bit7", 8'h00, 1'b0, 1'b1, 1'b0);
    step(1, 1, 1, 0, 0, 0);
    check("ff_word", 8'hFF, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
